// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: reloads instruction memory from the UART RX FIFO while holding the CPU in reset.
// Optional `IMEM_LOADER_CHECKSUM_EN adds a mod-256 checksum of the last loaded image.
module imem_loader_ctrl #(
  parameter int          DEPTH       = 512,
  parameter int          ADDR_W      = 9,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_full,
  input  logic [7:0]        fifo_rd,
  output logic [ADDR_W-1:0] fifo_ra,
  output logic              fifo_ra_sel,
  output logic              fifo_full_ack,
  output logic              cpu_reset_n,
  input  logic              cpu_mem_wen,
  input  logic [31:0]       cpu_mem_wa,
  input  logic [31:0]       cpu_mem_wd,
  input  logic [2:0]        cpu_mem_funct3,
  output logic              mem_wen,
  output logic [31:0]       mem_wa,
  output logic [31:0]       mem_wd,
  output logic [2:0]        mem_funct3,
  output logic              busy
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [7:0]        load_checksum
`endif
);
  typedef enum logic [2:0] {HOLD, IDLE, FILL, LAST, ACK, WAIT_CLR} state_t;
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          ld_wen;
  logic [31:0]   ld_wa;
  always_ff @(posedge clk)
    if (!reset_n) begin
      state         <= HOLD;
      cnt           <= CW'(HOLD_CYCLES - 1);
      fifo_ra       <= '0;
      fifo_ra_sel   <= 1'b0;
      fifo_full_ack <= 1'b0;
      cpu_reset_n   <= 1'b0;
      busy          <= 1'b1;
      ld_wen        <= 1'b0;
      ld_wa         <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      load_checksum <= '0;
`endif
    end else begin
      // write stage trails the FIFO read issue by one cycle, matching the FIFO read latency
      ld_wen        <= state == FILL;
      ld_wa         <= BASE_ADDR + 32'(fifo_ra);
      fifo_full_ack <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (state == IDLE && fifo_full)
        load_checksum <= '0;
      else if (ld_wen)
        load_checksum <= load_checksum + fifo_rd;
`endif
      case (state)
        HOLD:
          if (cnt == '0) begin
            state       <= IDLE;
            cpu_reset_n <= 1'b1;
            busy        <= 1'b0;
          end else
            cnt <= cnt - 1'b1;
        IDLE:
          if (fifo_full) begin
            state       <= FILL;
            fifo_ra     <= '0;
            fifo_ra_sel <= 1'b1;
            cpu_reset_n <= 1'b0;
            busy        <= 1'b1;
          end
        FILL:
          if (fifo_ra == ADDR_W'(DEPTH - 1)) begin
            state       <= LAST;
            fifo_ra     <= '0;
            fifo_ra_sel <= 1'b0;
          end else
            fifo_ra <= fifo_ra + 1'b1;
        LAST: begin
          state         <= ACK;
          fifo_full_ack <= 1'b1;
        end
        ACK: state <= WAIT_CLR;
        WAIT_CLR:
          if (!fifo_full) begin
            state <= HOLD;
            cnt   <= CW'(HOLD_CYCLES - 1);
          end
        default: state <= HOLD;
      endcase
    end
  // outside IDLE the CPU port is cut off; only loader writes reach memory
  assign mem_wen    = state == IDLE ? cpu_mem_wen : ld_wen;
  assign mem_wa     = state == IDLE ? cpu_mem_wa : ld_wen ? ld_wa : '0;
  assign mem_wd     = state == IDLE ? cpu_mem_wd : ld_wen ? {24'b0, fifo_rd} : '0;
  assign mem_funct3 = state == IDLE ? cpu_mem_funct3 : 3'b000;
endmodule
